exp_div_pipe: RTL and testbench
===============================

// Module: exp_div_pipe
// PURPOSE
//  Exponent path of the FP divider; counterpart of the multiplier exponent adder.
//  Computes the biased quotient exponent expq = expa - expb + BIAS - adj.
//  adj is the 1-bit normalisation correction from the mantissa divider (quotient < 1).
//  2-stage valid/ready pipeline; flags overflow/underflow with the same oom/vec meaning as the multiplier path.
// PARAMETERS
//  EW    8    exponent width (IEEE single)
//  BIAS  127  exponent bias; must equal 2**(EW-1)-1
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   operand strobe
//  in_ready   out  1   block can accept operands this cycle
//  expa       in   EW  dividend biased exponent
//  expb       in   EW  divisor biased exponent
//  adj        in   1   1 = subtract one more (quotient mantissa < 1)
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result this cycle
//  expq       out  EW  quotient biased exponent (saturated on oom)
//  oom        out  1   exponent out of range
//  vec        out  1   overflow direction: 1 = too large, 0 = too small (meaningful only when oom=1)
// BEHAVIOUR
//  - Handshake: a transfer occurs on any edge where valid & ready are both 1.
//    - in_ready = ~s1_v | ~s2_v | out_ready. Combinational, with no dependence on in_valid.
//    - Stage advance: s2 loads from s1 when (~s2_v | out_ready).
//    - Stage advance: s1 loads from the input when in_ready & in_valid.
//  - Latency: exactly 2 cycles from accept to out_valid when there is no stall.
//    Throughput is 1 result per cycle.
//  - Stage 1 registers d1 = {2'b00,expa} - {2'b00,expb}. This is an (EW+2)-bit two's-complement value, plus adj.
//  - Stage 2 computes r = d1 + BIAS - adj in EW+2 bits, then classifies and registers:
//    - r >= 2**EW-1 (all-ones exponent): oom=1, vec=1, expq = {EW{1'b1}}
//    - r <= 0: oom=1, vec=0, expq = 0
//    - otherwise: oom=0, vec=0, expq = r[EW-1:0]
//  - Boundaries: r==0 counts as underflow; r==2**EW-1 counts as overflow.
//    Inputs 0 and all-ones are treated as ordinary numbers; special operands are handled by the upstream classifier.
//  - Hold: while out_valid=1 & out_ready=0, expq/oom/vec/out_valid hold stable.
//    s1 also holds if occupied; in_ready drops only when both stages are full.
//  - Simultaneous events: with both stages full and out_ready=1, a new input is accepted the same cycle.
//    Nothing is lost or duplicated.
//  - Reset (including mid-operation): s1_v=s2_v=0, out_valid=0, expq=0, oom=0, vec=0.
//    in_ready=1 in the cycle after reset; in-flight operands are discarded.
//  - Data registers are cleared on reset, so X never reaches the outputs.
// TESTING
//  1 expa=0x80, expb=0x7F, adj=0 -> 2 cycles later out_valid=1, expq=0x80, oom=0.
//  2 expa=0x80, expb=0x01, adj=1 -> expq=0xFD, oom=0.
//    expa=0x7F, expb=0x7F, adj=1 -> expq=0x7E.
//  3 expa=0xFE, expb=0x01 -> oom=1, vec=1, expq=0xFF.
//    expa=0xFE, expb=0x7F (r=254) -> oom=0, expq=0xFE.
//    expa=0xFF, expb=0x7F (r=255) -> oom=1, vec=1.
//  4 expa=0x01, expb=0xFE -> oom=1, vec=0, expq=0x00.
//    expa=0x01, expb=0x80, adj=0 (r=0) -> oom=1, vec=0.
//  5 Stream 5 ops back-to-back with out_ready=0 for 4 cycles:
//    in_ready falls after 2 accepts and outputs hold stable.
//    Release -> all 5 results in order, 1 per cycle.
//  6 Assert rst with both stages full -> next cycle out_valid=0, oom=0, vec=0, expq=0, in_ready=1.
//    No stale result appears afterwards.

Source files
------------

// File: rtl/exp_div_pipe.sv
// Exponent path of the FP divider: expq = expa - expb + BIAS - adj, over a
// 2-stage valid/ready pipeline with saturating out-of-range flags (oom/vec).
module exp_div_pipe #(
  parameter int EW   = 8,
  parameter int BIAS = 127
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] expa,
  input  logic [EW-1:0] expb,
  input  logic          adj,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] expq,
  output logic          oom,
  output logic          vec
);

  localparam logic [EW+1:0] BIAS_W = (EW+2)'(BIAS);
  localparam logic [EW+1:0] EMAX_W = {2'b00, {EW{1'b1}}};

  // Packs {expq, oom, vec} from the stage-1 difference and the adj correction.
  function automatic logic [EW+1:0] classify(input logic [EW+1:0] d1, input logic aj);
    logic [EW+1:0] r;
    logic          neg;
    r   = d1 + BIAS_W - {{(EW+1){1'b0}}, aj};
    neg = r[EW+1];
    if (neg || (r == {(EW+2){1'b0}})) begin
      classify = {{EW{1'b0}}, 1'b1, 1'b0};
    end else if (r >= EMAX_W) begin
      classify = {{EW{1'b1}}, 1'b1, 1'b1};
    end else begin
      classify = {r[EW-1:0], 1'b0, 1'b0};
    end
  endfunction

  logic          s1_v_q, s1_v_d;
  logic [EW+1:0] d1_q, d1_d;
  logic          adj1_q, adj1_d;
  logic          s2_v_q, s2_v_d;
  logic [EW-1:0] expq_q, expq_d;
  logic          oom_q, oom_d;
  logic          vec_q, vec_d;
  logic          in_ready_s;
  logic          adv2_s;
  logic          acc1_s;
  logic [EW+1:0] cls_s;

  // Handshake decode and next-state for both pipeline stages.
  always_comb begin
    in_ready_s = ~s1_v_q | ~s2_v_q | out_ready;
    adv2_s     = ~s2_v_q | out_ready;
    acc1_s     = in_ready_s & in_valid;
    cls_s      = classify(d1_q, adj1_q);
    s1_v_d     = s1_v_q;
    d1_d       = d1_q;
    adj1_d     = adj1_q;
    s2_v_d     = s2_v_q;
    expq_d     = expq_q;
    oom_d      = oom_q;
    vec_d      = vec_q;

    // s1 may refill in the same cycle its content moves on to s2.
    if (acc1_s) begin
      s1_v_d = 1'b1;
      d1_d   = {2'b00, expa} - {2'b00, expb};
      adj1_d = adj;
    end else if (adv2_s) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end

    if (adv2_s) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        expq_d = cls_s[EW+1:2];
        oom_d  = cls_s[1];
        vec_d  = cls_s[0];
      end else begin
        expq_d = expq_q;
        oom_d  = oom_q;
        vec_d  = vec_q;
      end
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Pipeline registers with synchronous clear of state and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      d1_q   <= {(EW+2){1'b0}};
      adj1_q <= 1'b0;
      s2_v_q <= 1'b0;
      expq_q <= {EW{1'b0}};
      oom_q  <= 1'b0;
      vec_q  <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      d1_q   <= d1_d;
      adj1_q <= adj1_d;
      s2_v_q <= s2_v_d;
      expq_q <= expq_d;
      oom_q  <= oom_d;
      vec_q  <= vec_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = s2_v_q;
  assign expq      = expq_q;
  assign oom       = oom_q;
  assign vec       = vec_q;

endmodule

// File: tb/tb_exp_div_pipe.sv
// Self-checking bench for exp_div_pipe: directed vectors, stall/hold, reset
// flush and randomized traffic against an arithmetic reference scoreboard.
module tb_exp_div_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] expa;
  logic [7:0] expb;
  logic       adj;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] expq;
  logic       oom;
  logic       vec;

  int checks = 0;
  int errors = 0;
  logic [9:0] sbq[$];
  logic obs_ir, obs_ov, accepted;
  int   n_out;

  exp_div_pipe #(.EW(8), .BIAS(127)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .expa(expa), .expb(expb), .adj(adj), .out_valid(out_valid),
    .out_ready(out_ready), .expq(expq), .oom(oom), .vec(vec)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, result packed as {expq, oom, vec}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic aj);
    int r;
    logic [7:0] e;
    r = int'(a) - int'(b) + 127 - int'(aj);
    if (r >= 255) return {8'hFF, 1'b1, 1'b1};
    else if (r <= 0) return {8'h00, 1'b1, 1'b0};
    else begin
      e = r[7:0];
      return {e, 1'b0, 1'b0};
    end
  endfunction

  // One clock: drive at negedge, observe, and score transfers that occur at the next posedge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic aj, input logic ordy);
    logic [9:0] e;
    @(negedge clk);
    in_valid = v; expa = a; expb = b; adj = aj; out_ready = ordy;
    #1;
    obs_ir   = in_ready;
    obs_ov   = out_valid;
    accepted = v & in_ready;
    if (out_valid && ordy) begin
      n_out++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got expq=%h oom=%b vec=%b, expected no result", expq, oom, vec);
      end else begin
        e = sbq.pop_front();
        if ({expq, oom, vec} !== e) begin
          errors++;
          $display("FAIL sb_result: got expq=%h oom=%b vec=%b, expected expq=%h oom=%b vec=%b",
                   expq, oom, vec, e[9:2], e[1], e[0]);
        end
      end
    end
    if (accepted) sbq.push_back(model(a, b, aj));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic check_idle_state(input string tag);
    #1;
    checks++;
    if (out_valid !== 1'b0 || oom !== 1'b0 || vec !== 1'b0 || expq !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got ov=%b oom=%b vec=%b expq=%h ir=%b, expected 0 0 0 00 1",
               tag, out_valid, oom, vec, expq, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; expa = 8'h00; expb = 8'h00; adj = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_state("reset_state");
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic aj);
    cycle(1'b1, a, b, aj, 1'b1);
    checks++;
    if (accepted !== 1'b1) begin errors++; $display("FAIL lat_accept: got in_ready=%b, expected 1", obs_ir); end
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_ov !== 1'b0) begin errors++; $display("FAIL lat_early: got out_valid=%b after 1 cycle, expected 0", obs_ov); end
    n_out = 0;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_ov !== 1'b1 || n_out != 1) begin errors++; $display("FAIL lat_2cyc: got out_valid=%b after 2 cycles, expected 1", obs_ov); end
  endtask

  task automatic test_directed();
    run_one(8'h80, 8'h7F, 1'b0);
    run_one(8'h80, 8'h01, 1'b1);
    run_one(8'h7F, 8'h7F, 1'b1);
    run_one(8'hFE, 8'h01, 1'b0);
    run_one(8'hFE, 8'h7F, 1'b0);
    run_one(8'hFF, 8'h7F, 1'b0);
    run_one(8'h01, 8'hFE, 1'b0);
    run_one(8'h01, 8'h80, 1'b0);
    run_one(8'hFF, 8'h80, 1'b1);
    run_one(8'h00, 8'hFF, 1'b1);
  endtask

  task automatic test_stall();
    logic [7:0] a[5], b[5];
    logic [9:0] first;
    int k, rel;
    for (int i = 0; i < 5; i++) begin a[i] = 8'(20 + 30*i); b[i] = 8'(10 + 7*i); end
    first = model(a[0], b[0], 1'b0);
    k = 0;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, a[k], b[k], 1'b0, 1'b0);
      if (accepted) k++;
    end
    checks++;
    if (k != 2) begin errors++; $display("FAIL stall_accepts: got %0d accepts, expected 2", k); end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, a[k], b[k], 1'b0, 1'b0);
      if (accepted) k++;
      checks++;
      if (obs_ir !== 1'b0 || obs_ov !== 1'b1 || {expq, oom, vec} !== first) begin
        errors++;
        $display("FAIL stall_hold: got ir=%b ov=%b expq=%h oom=%b vec=%b, expected ir=0 ov=1 expq=%h",
                 obs_ir, obs_ov, expq, oom, vec, first[9:2]);
      end
    end
    n_out = 0;
    rel = 0;
    while (n_out < 5 && rel < 20) begin
      if (k < 5) begin
        cycle(1'b1, a[k], b[k], 1'b0, 1'b1);
        if (accepted) k++;
      end else begin
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      end
      rel++;
    end
    checks++;
    if (n_out != 5 || rel != 5) begin
      errors++;
      $display("FAIL stall_release: got %0d results in %0d cycles, expected 5 in 5", n_out, rel);
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 3; c++) cycle(1'b1, 8'h90, 8'h10, 1'b0, 1'b0);
    checks++;
    if (obs_ir !== 1'b0) begin errors++; $display("FAIL rst_fill: got in_ready=%b, expected 0", obs_ir); end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    sbq.delete();
    check_idle_state("rst_midflight");
    n_out = 0;
    for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++;
    if (n_out != 0) begin errors++; $display("FAIL rst_stale: got %0d results, expected 0", n_out); end
    run_one(8'h85, 8'h03, 1'b1);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] edges[6];
    edges = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    else return 8'($urandom);
  endfunction

  task automatic test_random();
    int drain;
    n_out = 0;
    for (int c = 0; c < 400; c++)
      cycle(1'($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom),
            1'($urandom_range(0, 3) != 0));
    drain = 0;
    while (sbq.size() != 0 && drain < 10) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      drain++;
    end
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending, expected 0", sbq.size()); end
    checks++;
    if (n_out < 100) begin errors++; $display("FAIL rand_traffic: got %0d results, expected at least 100", n_out); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_midflight();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
